// File: rtl/reg_file_16.sv
// 16-entry register file written through a one-hot select, two registered read ports with write bypass.
// Read latency 1 cycle, no backpressure; a non-one-hot write vector is dropped and flagged.
module reg_file_16 #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [15:0]       wr_onehot,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [3:0]        rd_addr_a,
  input  logic [3:0]        rd_addr_b,
  input  logic              clr_err,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              wr_err,
  output logic              err_sticky
);

  logic [DATA_W-1:0] regs [16];
  logic              one_hot;
  logic              legal;
  logic              illegal;

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing.
  assign one_hot = (wr_onehot != 16'd0) && ((wr_onehot & (wr_onehot - 16'd1)) == 16'd0);
  assign legal   = wr_en & one_hot;
  assign illegal = wr_en & ~one_hot;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) regs[i] <= '0;
    end else if (legal) begin
      for (int i = 0; i < 16; i++) begin
        if (wr_onehot[i]) regs[i] <= wr_data;
      end
    end
  end

  // The write select is one-hot when legal, so indexing it by the read address detects a hit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_a <= '0;
      rd_data_b <= '0;
    end else begin
      rd_data_a <= (legal && wr_onehot[rd_addr_a]) ? wr_data : regs[rd_addr_a];
      rd_data_b <= (legal && wr_onehot[rd_addr_b]) ? wr_data : regs[rd_addr_b];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_err     <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      wr_err <= illegal;
      if (illegal)      err_sticky <= 1'b1;
      else if (clr_err) err_sticky <= 1'b0;
    end
  end

endmodule
